// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock/tick divider with free-running scan select.
// Optional half-period/pending readback port set is enabled by defining CLK_DIV_READBACK_EN.
module clk_div_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 27,
  parameter int DEF_HALF = 50000000,
  parameter int SCAN_W = 2,
  parameter int SCAN_LSB = 15,
  localparam int DW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [DW-1:0]     div_ch,
  input  logic [CNT_W-1:0]  div_value,
`ifdef CLK_DIV_READBACK_EN
  input  logic [DW-1:0]     rd_ch,
  output logic [CNT_W-1:0]  rd_half,
  output logic [NUM_CH-1:0] rd_pend,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [SCAN_W-1:0] clk_scan
);
  localparam int SW = SCAN_LSB + SCAN_W;
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] half [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ld;
  logic [SW-1:0] scan_cnt;
  // out-of-range div_ch shifts the one-hot select to zero, so the load is dropped
  assign ld = div_load ? NUM_CH'(1) << div_ch : '0;
  assign clk_scan = scan_cnt[SW-1:SCAN_LSB];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out <= '0;
      tick <= '0;
      pend <= '0;
      scan_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        half[i] <= RST_HALF;
        shadow[i] <= RST_HALF;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= ld[i] ? div_value : shadow[i];
        if (sync_clr) begin
          cnt[i] <= '0;
          clk_out[i] <= 1'b0;
          tick[i] <= 1'b0;
          half[i] <= ld[i] ? div_value : (pend[i] ? shadow[i] : half[i]);
          pend[i] <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i] <= '0;
          clk_out[i] <= 1'b0;
          tick[i] <= 1'b0;
          half[i] <= pend[i] ? shadow[i] : half[i];
          pend[i] <= ld[i];
        end else if (cnt[i] == half[i]) begin
          // terminal count uses the old half; a load landing now stays pending
          cnt[i] <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i] <= 1'b1;
          half[i] <= pend[i] ? shadow[i] : half[i];
          pend[i] <= ld[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
          tick[i] <= 1'b0;
          pend[i] <= pend[i] | ld[i];
        end
      end
    end
  end
`ifdef CLK_DIV_READBACK_EN
  logic [NUM_CH-1:0] rd_sel;
  logic [CNT_W-1:0] rd_mux;
  assign rd_sel = NUM_CH'(1) << rd_ch;
  assign rd_pend = pend;
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) rd_mux = rd_mux | (rd_sel[i] ? half[i] : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_half <= '0;
    else rd_half <= rd_mux;
  end
`endif
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed bench with an elapsed-time reference model for clk_div_multi.
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ch_en = 2'b11;
  logic sync_clr = 1'b0;
  logic div_load = 1'b0;
  logic [0:0] div_ch = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic [1:0] clk_out, tick, clk_scan;
  int vecs = 0;
  int errs = 0;

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEF_HALF(4), .SCAN_W(2), .SCAN_LSB(2)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync_clr(sync_clr), .div_load(div_load),
    .div_ch(div_ch), .div_value(div_value), .clk_out(clk_out), .tick(tick), .clk_scan(clk_scan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: each channel remembers the edge where its count last restarted
  int edges;
  int ma [2];
  int mh [2];
  int msh [2];
  bit mp [2];
  logic [1:0] lvl, tk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0;
      lvl = '0;
      tk = '0;
      for (int c = 0; c < 2; c++) begin
        ma[c] = 0; mh[c] = 4; msh[c] = 4; mp[c] = 0;
      end
    end else begin
      edges++;
      for (int c = 0; c < 2; c++) begin
        bit ld;
        ld = div_load && (int'(div_ch) == c);
        if (sync_clr) begin
          lvl[c] = 1'b0; tk[c] = 1'b0; ma[c] = edges;
          if (ld) msh[c] = int'(div_value);
          mh[c] = msh[c]; mp[c] = 0;
        end else if (!ch_en[c]) begin
          lvl[c] = 1'b0; tk[c] = 1'b0; ma[c] = edges;
          if (mp[c]) mh[c] = msh[c];
          mp[c] = 0;
          if (ld) begin msh[c] = int'(div_value); mp[c] = 1; end
        end else begin
          if (edges - ma[c] == mh[c] + 1) begin
            lvl[c] = ~lvl[c]; tk[c] = 1'b1; ma[c] = edges;
            if (mp[c]) mh[c] = msh[c];
            mp[c] = 0;
          end else tk[c] = 1'b0;
          if (ld) begin msh[c] = int'(div_value); mp[c] = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_clk_out", 32'(clk_out), 32'(lvl));
    chk("model_tick", 32'(tick), 32'(tk));
    chk("model_clk_scan", 32'(clk_scan), 32'((edges % 16) / 4));
  end

  task automatic till(input int k);
    int guard;
    guard = 0;
    while (edges < k && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (edges != k) chk("till_edge", 32'(edges), 32'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edges %0d", edges);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_scan", 32'(clk_scan), 32'h0);
    rst_n = 1'b1;
    till(4);  chk("t1_e4_out", 32'(clk_out), 32'h0); chk("t1_e4_tick", 32'(tick), 32'h0);
    till(5);  chk("t1_e5_out", 32'(clk_out), 32'h3); chk("t1_e5_tick", 32'(tick), 32'h3);
    chk("t1_e5_scan", 32'(clk_scan), 32'h1);
    till(10); chk("t1_e10_out", 32'(clk_out), 32'h0); chk("t1_e10_tick", 32'(tick), 32'h3);
    till(15); chk("t1_e15_tick", 32'(tick), 32'h3); chk("t1_e15_scan", 32'(clk_scan), 32'h3);
    till(16); chk("t5_wrap_scan", 32'(clk_scan), 32'h0); chk("t1_e16_tick", 32'(tick), 32'h0);
    till(18); div_load = 1'b1; div_ch = 1'b0; div_value = 8'd1;
    till(19); div_load = 1'b0;
    till(20); chk("t2_old_half_out0", 32'(clk_out[0]), 32'h0); chk("t2_old_half_tick0", 32'(tick[0]), 32'h1);
    till(21); chk("t2_e21_tick0", 32'(tick[0]), 32'h0);
    till(22); chk("t2_new_half_out0", 32'(clk_out[0]), 32'h1); chk("t2_e22_tick0", 32'(tick[0]), 32'h1);
    till(24); chk("t2_e24_out0", 32'(clk_out[0]), 32'h0);
    till(26); chk("t3_pre_out1", 32'(clk_out[1]), 32'h1); ch_en = 2'b01;
    till(27); chk("t3_dis_out1", 32'(clk_out[1]), 32'h0);
    till(28); ch_en = 2'b11;
    till(32); chk("t3_e32_tick1", 32'(tick[1]), 32'h0); chk("t3_e32_out1", 32'(clk_out[1]), 32'h0);
    till(33); chk("t3_first_tick1", 32'(tick[1]), 32'h1); chk("t3_first_out1", 32'(clk_out[1]), 32'h1);
    till(35); sync_clr = 1'b1; div_load = 1'b1; div_ch = 1'b1; div_value = 8'd2;
    till(36); sync_clr = 1'b0; div_load = 1'b0;
    chk("t4_clr_out", 32'(clk_out), 32'h0); chk("t4_clr_tick", 32'(tick), 32'h0);
    chk("t4_clr_scan", 32'(clk_scan), 32'h1);
    till(39); chk("t4_e39_out1", 32'(clk_out[1]), 32'h1); chk("t4_e39_tick1", 32'(tick[1]), 32'h1);
    till(40); chk("t4_e40_scan", 32'(clk_scan), 32'h2);
    till(42); chk("t4_e42_out1", 32'(clk_out[1]), 32'h0);
    till(43); div_load = 1'b1; div_ch = 1'b0; div_value = 8'd7;
    till(44); div_load = 1'b0;
    till(50); chk("t6_pre_out", 32'(clk_out), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out", 32'(clk_out), 32'h0);
    chk("t6_async_tick", 32'(tick), 32'h0);
    chk("t6_async_scan", 32'(clk_scan), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    till(4);  chk("t6_e4_out", 32'(clk_out), 32'h0);
    till(5);  chk("t6_def_out", 32'(clk_out), 32'h3); chk("t6_def_tick", 32'(tick), 32'h3);
    till(10); chk("t6_e10_out", 32'(clk_out), 32'h0);
    till(12);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
